// File: rtl/seg_scan_decoder.sv
// Seven-segment scan monitor: rebuilds per-digit hex values from multiplexed active-low anode/cathode lines.
// Optional per-digit refresh timeout when SEG_DIGIT_TIMEOUT_EN is defined.
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    upd,
    output logic [IDX_W-1:0]        upd_idx
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    if (NUM_DIGITS < 1 || STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("seg_scan_decoder: illegal parameter value");
    end

    // Returns {legal, blank, value}; anything neither legal nor blank is an error glyph.
    function automatic logic [5:0] f_decode(input logic [6:0] s);
        case (s)
            7'b0000001: return {2'b10, 4'h0};
            7'b1001111: return {2'b10, 4'h1};
            7'b0010010: return {2'b10, 4'h2};
            7'b0000110: return {2'b10, 4'h3};
            7'b1001100: return {2'b10, 4'h4};
            7'b0100100: return {2'b10, 4'h5};
            7'b0100000: return {2'b10, 4'h6};
            7'b0001111: return {2'b10, 4'h7};
            7'b0000000: return {2'b10, 4'h8};
            7'b0001100: return {2'b10, 4'h9};
            7'b0001000: return {2'b10, 4'hA};
            7'b1100000: return {2'b10, 4'hB};
            7'b0110001: return {2'b10, 4'hC};
            7'b1000010: return {2'b10, 4'hD};
            7'b0110000: return {2'b10, 4'hE};
            7'b0111000: return {2'b10, 4'hF};
            7'b1111111: return {2'b01, 4'h0};
            default:    return {2'b00, 4'h0};
        endcase
    endfunction

    logic [NUM_DIGITS-1:0]   r_an, r_an_prev;
    logic [6:0]              r_seg, r_seg_prev;
    state_t                  r_state, w_state_nx;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic                    w_accept;
    logic                    w_addr, w_same;
    logic [IDX_W-1:0]        w_idx;
    logic [5:0]              w_dec;
    logic                    w_legal, w_illegal;
    logic [NUM_DIGITS-1:0]   w_acc_mask, w_valid_base, w_valid_nx, w_err_nx;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid, r_err;
    logic                    r_upd;
    logic [IDX_W-1:0]        r_upd_idx;

    // Input capture runs through reset so a fresh count starts from clean history.
    always_ff @(posedge clk) begin
        r_an       <= an;
        r_seg      <= seg;
        r_an_prev  <= r_an;
        r_seg_prev <= r_seg;
    end

    // Sample classification and selected-digit index.
    always_comb begin
        w_addr = $onehot(~r_an);
        w_same = (r_an == r_an_prev) && (r_seg == r_seg_prev);
        w_idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_idx = w_idx | (r_an[i] ? IDX_W'(0) : IDX_W'(i));
        end
        w_dec     = f_decode(r_seg);
        w_legal   = w_dec[5];
        w_illegal = ~w_dec[5] & ~w_dec[4];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // FSM next-state: a sample must repeat STABLE_CYCLES times before it is accepted.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_addr) begin
                    w_state_nx = ST_TRACK;
                    w_cnt_nx   = CNT_W'(1);
                end else begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            ST_TRACK: begin
                if (w_same) begin
                    if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        w_state_nx = ST_LOCKED;
                        w_cnt_nx   = CNT_W'(STABLE_CYCLES);
                        w_accept   = 1'b1;
                    end else begin
                        w_cnt_nx   = r_cnt + CNT_W'(1);
                    end
                end else if (w_addr) begin
                    w_state_nx = ST_TRACK;
                    w_cnt_nx   = CNT_W'(1);
                end else begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_same) begin
                    w_state_nx = ST_LOCKED;
                end else if (w_addr) begin
                    w_state_nx = ST_TRACK;
                    w_cnt_nx   = CNT_W'(1);
                end else begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

`ifdef SEG_DIGIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_DIGITS-1:0][TMO_W-1:0] r_tmo;
    logic [NUM_DIGITS-1:0]            w_tmo_hit;

    // Per-digit refresh counters, saturating at TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_acc_mask[i]) begin
                    r_tmo[i] <= '0;
                end else if (r_tmo[i] != TMO_W'(TIMEOUT_CYCLES)) begin
                    r_tmo[i] <= r_tmo[i] + TMO_W'(1);
                end
            end
        end
    end

    // Timeout fires on the edge where a counter reaches TIMEOUT_CYCLES.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_tmo_hit[i] = (r_tmo[i] == TMO_W'(TIMEOUT_CYCLES - 1));
        end
        w_valid_base = r_valid & ~w_tmo_hit;
    end
`else
    assign w_valid_base = r_valid;
`endif

    // Next valid/err; acceptance overrides timeout, an error set overrides err_clr.
    always_comb begin
        w_acc_mask = w_accept ? (NUM_DIGITS'(1) << w_idx) : '0;
        w_valid_nx = (w_valid_base & ~w_acc_mask) | (w_legal ? w_acc_mask : '0);
        w_err_nx   = (err_clr ? '0 : r_err) | (w_illegal ? w_acc_mask : '0);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits  <= '0;
            r_valid   <= '0;
            r_err     <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= '0;
        end else begin
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
            r_upd   <= w_accept;
            if (w_accept) begin
                r_upd_idx <= w_idx;
            end
            if (w_accept && w_legal) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
            end
        end
    end

    assign digits  = r_digits;
    assign valid   = r_valid;
    assign err     = r_err;
    assign upd     = r_upd;
    assign upd_idx = r_upd_idx;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (4 digits, STABLE_CYCLES=4).
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        upd;
    logic [1:0]  upd_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100000)
    ) u_dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .err_clr(err_clr),
        .digits(digits), .valid(valid), .err(err), .upd(upd), .upd_idx(upd_idx)
    );

`ifdef SEG_DIGIT_TIMEOUT_EN
    logic [15:0] t_digits;
    logic [3:0]  t_valid;
    logic [3:0]  t_err;
    logic        t_upd;
    logic [1:0]  t_upd_idx;

    seg_scan_decoder #(
        .NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)
    ) u_dut_tmo (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .err_clr(err_clr),
        .digits(t_digits), .valid(t_valid), .err(t_err), .upd(t_upd), .upd_idx(t_upd_idx)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) upd_cnt++;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        drive(4'b1111, 7'b1111111);
        run(3);
        chk("rst_digits", {16'h0, digits}, 32'h0);
        chk("rst_valid", {28'h0, valid}, 32'h0);
        chk("rst_err", {28'h0, err}, 32'h0);
        chk("rst_upd", {31'h0, upd}, 32'h0);
        chk("rst_upd_idx", {30'h0, upd_idx}, 32'h0);
        rst = 1'b0;

        // Single digit "2" on digit 0: acceptance exactly 4 edges after capture.
        drive(4'b1110, 7'b0010010);
        upd_cnt = 0;
        run(4);
        chk("t1_early", upd_cnt, 32'd0);
        run(1);
        chk("t1_upd", {31'h0, upd}, 32'h1);
        chk("t1_idx", {30'h0, upd_idx}, 32'h0);
        chk("t1_digit0", {28'h0, digits[3:0]}, 32'h2);
        chk("t1_valid", {28'h0, valid}, 32'h1);
        upd_cnt = 0;
        run(10);
        chk("t1_hold_noupd", upd_cnt, 32'd0);

        // Scan 7, A, 0, F across digits 0..3.
        upd_cnt = 0;
        drive(4'b1110, 7'b0001111); run(8);
        drive(4'b1101, 7'b0001000); run(8);
        drive(4'b1011, 7'b0000001); run(8);
        drive(4'b0111, 7'b0111000); run(8);
        chk("t2_upd_count", upd_cnt, 32'd4);
        chk("t2_digits", {16'h0, digits}, 32'hF0A7);
        chk("t2_valid", {28'h0, valid}, 32'hF);
        chk("t2_err", {28'h0, err}, 32'h0);
        chk("t2_idx", {30'h0, upd_idx}, 32'h3);

        // 3-cycle glitch on digit 1 between two stable frames of digit 0.
        upd_cnt = 0;
        drive(4'b1110, 7'b0001111); run(8);
        drive(4'b1101, 7'b0000000); run(3);
        drive(4'b1110, 7'b0001111); run(8);
        chk("t3_upd_count", upd_cnt, 32'd2);
        chk("t3_digits", {16'h0, digits}, 32'hF0A7);
        chk("t3_valid", {28'h0, valid}, 32'hF);
        chk("t3_idx", {30'h0, upd_idx}, 32'h0);

        // Illegal glyph on digit 2, then clear.
        upd_cnt = 0;
        drive(4'b1011, 7'b1010101); run(6);
        chk("t4_upd_count", upd_cnt, 32'd1);
        chk("t4_err", {28'h0, err}, 32'h4);
        chk("t4_valid", {28'h0, valid}, 32'hB);
        chk("t4_digits", {16'h0, digits}, 32'hF0A7);
        chk("t4_idx", {30'h0, upd_idx}, 32'h2);
        err_clr = 1'b1; run(1); err_clr = 1'b0;
        chk("t4_err_clr", {28'h0, err}, 32'h0);
        chk("t4_valid_after_clr", {28'h0, valid}, 32'hB);

        // New error on digit 3 coinciding with err_clr: set wins, digit 1 clears.
        drive(4'b1101, 7'b1010101); run(6);
        chk("t5_err_d1", {28'h0, err}, 32'h2);
        chk("t5_valid_d1", {28'h0, valid}, 32'h9);
        drive(4'b0111, 7'b1111110); run(4);
        err_clr = 1'b1; run(1); err_clr = 1'b0;
        chk("t5_upd", {31'h0, upd}, 32'h1);
        chk("t5_err_setwins", {28'h0, err}, 32'h8);
        chk("t5_valid", {28'h0, valid}, 32'h1);
        chk("t5_digits", {16'h0, digits}, 32'hF0A7);

        // Blank on digit 0: upd, valid drops, no error, value kept.
        upd_cnt = 0;
        drive(4'b1110, 7'b1111111); run(6);
        chk("t6_upd_count", upd_cnt, 32'd1);
        chk("t6_valid", {28'h0, valid}, 32'h0);
        chk("t6_err", {28'h0, err}, 32'h8);
        chk("t6_digits", {16'h0, digits}, 32'hF0A7);

        // Non-addressable anode patterns never produce an update.
        upd_cnt = 0;
        drive(4'b0011, 7'b0000000); run(20);
        drive(4'b1111, 7'b0000001); run(20);
        drive(4'b0000, 7'b0001111); run(20);
        chk("t7_no_upd", upd_cnt, 32'd0);
        chk("t7_digits", {16'h0, digits}, 32'hF0A7);

        // Reset in the middle of a count; a full fresh count follows.
        drive(4'b1110, 7'b0100100); run(3);
        rst = 1'b1; run(1); rst = 1'b0;
        chk("t8_rst_digits", {16'h0, digits}, 32'h0);
        chk("t8_rst_valid", {28'h0, valid}, 32'h0);
        chk("t8_rst_err", {28'h0, err}, 32'h0);
        chk("t8_rst_upd", {31'h0, upd}, 32'h0);
        upd_cnt = 0;
        run(3);
        chk("t8_early", upd_cnt, 32'd0);
        run(1);
        chk("t8_upd", {31'h0, upd}, 32'h1);
        chk("t8_digits", {16'h0, digits}, 32'h0005);
        chk("t8_valid", {28'h0, valid}, 32'h1);

        // Display goes dark after the digit 0 acceptance.
        drive(4'b1111, 7'b1111111);
`ifdef SEG_DIGIT_TIMEOUT_EN
        run(49);
        chk("t9_valid_before_tmo", {31'h0, t_valid[0]}, 32'h1);
        run(1);
        chk("t9_valid_tmo", {31'h0, t_valid[0]}, 32'h0);
        chk("t9_digit_kept", {28'h0, t_digits[3:0]}, 32'h5);
`else
        run(60);
        chk("t9_valid_held", {28'h0, valid}, 32'h1);
        chk("t9_digits_held", {16'h0, digits}, 32'h0005);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
